// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// The master drives a request with sized byte enables; the slave answers with
// dmem_ready and, for reads, the addressed word on dmem_rdata.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: turns the EX/MEM register into a sized
// data-memory access, waits out slow memories (with a timeout), extends load
// data and produces the MEM/WB register. Upstream is frozen via mem_stall
// while an access is outstanding.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_regwrite_e,
    input  logic [1:0]  ex_mem_result_src_e,
    input  logic        ex_mem_memwrite_e,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] writedata,
    input  logic [31:0] ex_mem_pc_plus_4_e,
    input  logic [4:0]  ex_mem_rd,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic        mem_wb_regwrite,
    output logic [1:0]  mem_wb_result_src,
    output logic [31:0] mem_wb_alu_result,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_pc_plus_4,
    output logic [4:0]  mem_wb_rd,
    output logic        misalign_fault,
    output logic        bus_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  resultSrc;
        logic [31:0] aluResult;
        logic [31:0] readData;
        logic [31:0] pcPlus4;
        logic [4:0]  rd;
    } mem_wb_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    mem_wb_t          memWb_q, memWb_d;
    logic             misalign_q, misalign_d;
    logic             busErr_q, busErr_d;

    logic        isLoad, isStore, memOp, legal, aligned, accessOk;
    logic        req, abort, fault, stall;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;

    // Classify the EX/MEM instruction: is it a memory op, is its funct3 legal, is it aligned.
    always_comb begin
        isLoad  = (ex_mem_result_src_e == 2'b01);
        isStore = ex_mem_memwrite_e;
        memOp   = isLoad | isStore;
        if (isStore) begin
            legal = ex_mem_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = ex_mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (ex_mem_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~alu_result[0];
            default: aligned = (alu_result[1:0] == 2'b00);
        endcase
        accessOk = legal & aligned;
    end

    // Access FSM: request in IDLE, hold it in WAIT until ready or timeout; reset kills the access.
    always_comb begin
        req       = 1'b0;
        abort     = 1'b0;
        fault     = 1'b0;
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (memOp) begin
                        if (accessOk) begin
                            req = 1'b1;
                            if (!dmem.dmem_ready) begin
                                state_d   = WAIT;
                                waitCnt_d = CNT_W'(1);
                            end
                        end else begin
                            fault = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    req = 1'b1;
                    if (dmem.dmem_ready) begin
                        state_d   = IDLE;
                        waitCnt_d = '0;
                    end else if (waitCnt_q == TIMEOUT_VAL) begin
                        abort     = 1'b1;
                        state_d   = IDLE;
                        waitCnt_d = '0;
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    waitCnt_d = '0;
                end
            endcase
        end
        stall = req & ~dmem.dmem_ready & ~abort;
    end

    // Bus drive: word address, lane enables and store data replicated into every lane.
    always_comb begin
        dmem.dmem_req   = req;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_be    = '0;
        dmem.dmem_wdata = '0;
        if (req) begin
            dmem.dmem_addr = {alu_result[31:2], 2'b00};
            dmem.dmem_we   = isStore;
            dmem.dmem_be   = 4'b1111;
            if (isStore) begin
                case (ex_mem_funct3[1:0])
                    2'b00: begin
                        dmem.dmem_be    = 4'b0001 << alu_result[1:0];
                        dmem.dmem_wdata = {4{writedata[7:0]}};
                    end
                    2'b01: begin
                        dmem.dmem_be    = 4'b0011 << alu_result[1:0];
                        dmem.dmem_wdata = {2{writedata[15:0]}};
                    end
                    default: dmem.dmem_wdata = writedata;
                endcase
            end
        end
    end

    // Pick the addressed byte/half out of the read word and sign- or zero-extend it.
    always_comb begin
        case (alu_result[1:0])
            2'b00:   byteSel = dmem.dmem_rdata[7:0];
            2'b01:   byteSel = dmem.dmem_rdata[15:8];
            2'b10:   byteSel = dmem.dmem_rdata[23:16];
            default: byteSel = dmem.dmem_rdata[31:24];
        endcase
        halfSel = alu_result[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (ex_mem_funct3)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b100:  loadData = {24'h0, byteSel};
            3'b101:  loadData = {16'h0, halfSel};
            default: loadData = dmem.dmem_rdata;
        endcase
    end

    // Next MEM/WB contents: bubble on stall, fault or abort, otherwise pass the instruction on.
    always_comb begin
        memWb_d    = '0;
        misalign_d = fault;
        busErr_d   = abort;
        if (!(stall | fault | abort)) begin
            memWb_d.regwrite  = ex_mem_regwrite_e;
            memWb_d.resultSrc = ex_mem_result_src_e;
            memWb_d.aluResult = alu_result;
            memWb_d.readData  = isLoad ? loadData : 32'h0;
            memWb_d.pcPlus4   = ex_mem_pc_plus_4_e;
            memWb_d.rd        = ex_mem_rd;
        end
    end

    // State, wait counter, MEM/WB register and the fault pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            memWb_q    <= '0;
            misalign_q <= 1'b0;
            busErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            memWb_q    <= memWb_d;
            misalign_q <= misalign_d;
            busErr_q   <= busErr_d;
        end
    end

    assign mem_stall         = stall;
    assign mem_wb_regwrite   = memWb_q.regwrite;
    assign mem_wb_result_src = memWb_q.resultSrc;
    assign mem_wb_alu_result = memWb_q.aluResult;
    assign mem_wb_read_data  = memWb_q.readData;
    assign mem_wb_pc_plus_4  = memWb_q.pcPlus4;
    assign mem_wb_rd         = memWb_q.rd;
    assign misalign_fault    = misalign_q;
    assign bus_error         = busErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instructions with chosen wait-state counts.
// Each instruction is expanded into a per-cycle timeline of expected bus and
// MEM/WB values; a compare process checks the DUT against it every cycle.
module tb_mem_stage;

    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  src;
        logic        memwrite;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        fault;
        logic        berr;
    } wb_t;

    typedef struct packed {
        logic        req;
        logic        stall;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        wb_t         wb;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        regwriteE, memwriteE;
    logic [1:0]  resultSrcE;
    logic [2:0]  funct3E;
    logic [31:0] aluResult, writeData, pcPlus4E;
    logic [4:0]  rdE;
    logic        memStall, wbRegwrite, misalignFault, busError;
    logic [1:0]  wbResultSrc;
    logic [31:0] wbAluResult, wbReadData, wbPcPlus4;
    logic [4:0]  wbRd;

    int   compared   = 0;
    int   mismatched = 0;
    int   stallCount = 0;
    exp_t expQ[$];
    wb_t  pendingWb;
    op_t  nop;

    mem_stage_if dmemIf ();

    mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ex_mem_regwrite_e   (regwriteE),
        .ex_mem_result_src_e (resultSrcE),
        .ex_mem_memwrite_e   (memwriteE),
        .ex_mem_funct3       (funct3E),
        .alu_result          (aluResult),
        .writedata           (writeData),
        .ex_mem_pc_plus_4_e  (pcPlus4E),
        .ex_mem_rd           (rdE),
        .dmem                (dmemIf),
        .mem_stall           (memStall),
        .mem_wb_regwrite     (wbRegwrite),
        .mem_wb_result_src   (wbResultSrc),
        .mem_wb_alu_result   (wbAluResult),
        .mem_wb_read_data    (wbReadData),
        .mem_wb_pc_plus_4    (wbPcPlus4),
        .mem_wb_rd           (wbRd),
        .misalign_fault      (misalignFault),
        .bus_error           (busError)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which the DUT holds the pipeline.
    always @(negedge clk) if (memStall === 1'b1) stallCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic op_t mkOp(input logic rw, input logic [1:0] src, input logic mw, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                                 input logic [4:0] rd);
        op_t o;
        o.regwrite = rw; o.src = src; o.memwrite = mw; o.f3 = f3;
        o.alu = alu; o.wd = wd; o.pc = pc; o.rd = rd;
        return o;
    endfunction

    // Load extension from the ISA rules, using arithmetic on lane offsets.
    function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        int unsigned off, b, h;
        off = addr % 4;
        b   = (word >> (8 * off)) & 32'd255;
        h   = (word >> (8 * off)) & 32'd65535;
        case (f3)
            3'b000:  return (b >= 128)   ? b + 32'hFFFFFF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic wb_t passWb(input op_t o, input logic [31:0] rdata);
        wb_t w;
        w = '0;
        w.regwrite = o.regwrite; w.src = o.src; w.alu = o.alu;
        w.rdata = rdata; w.pc = o.pc; w.rd = o.rd;
        return w;
    endfunction

    task automatic driveOp(input op_t o);
        regwriteE = o.regwrite; resultSrcE = o.src; memwriteE = o.memwrite; funct3E = o.f3;
        aluResult = o.alu; writeData = o.wd; pcPlus4E = o.pc; rdE = o.rd;
    endtask

    // Issue one instruction; memory answers after 'waits' not-ready cycles.
    task automatic applyStimulus(input op_t o, input int waits, input logic [31:0] rdata);
        exp_t        e;
        wb_t         nxt;
        bit          done;
        bit          isLoad, isStore, legal, aligned;
        int unsigned nBytes, off, b, h;
        int          j;
        isLoad  = (o.src == 2'b01);
        isStore = o.memwrite;
        legal   = isStore ? (o.f3 inside {3'd0, 3'd1, 3'd2}) : (o.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nBytes  = (o.f3[1:0] == 2'd0) ? 1 : (o.f3[1:0] == 2'd1) ? 2 : 4;
        aligned = ((o.alu % nBytes) == 0);
        off     = o.alu % 4;
        b       = o.wd & 32'd255;
        h       = o.wd & 32'd65535;
        j       = 0;
        done    = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            driveOp(o);
            e    = '0;
            e.wb = pendingWb;
            dmemIf.dmem_ready = 1'b0;
            dmemIf.dmem_rdata = 32'hA5A5A5A5;
            if (!(isLoad || isStore)) begin
                nxt  = passWb(o, 32'h0);
                done = 1'b1;
            end else if (!(legal && aligned)) begin
                nxt       = '0;
                nxt.fault = 1'b1;
                done      = 1'b1;
            end else begin
                e.req  = 1'b1;
                e.we   = isStore;
                e.addr = o.alu - off;
                e.be   = 4'hF;
                if (isStore) begin
                    if (nBytes == 1) begin
                        e.be = 4'(1 << off); e.wdata = b * 32'h01010101;
                    end else if (nBytes == 2) begin
                        e.be = 4'(3 << off); e.wdata = h * 32'h00010001;
                    end else begin
                        e.wdata = o.wd;
                    end
                end
                if (j == waits) begin
                    dmemIf.dmem_ready = 1'b1;
                    dmemIf.dmem_rdata = rdata;
                    nxt  = passWb(o, isLoad ? extendLoad(o.f3, o.alu, rdata) : 32'h0);
                    done = 1'b1;
                end else if (j == TIMEOUT) begin
                    nxt      = '0;
                    nxt.berr = 1'b1;
                    done     = 1'b1;
                end else begin
                    e.stall = 1'b1;
                    nxt     = '0;
                end
            end
            expQ.push_back(e);
            pendingWb = nxt;
            j++;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(nop, 0, 32'h0);
    endtask

    // Per-cycle comparison of the DUT against the expected timeline.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("dmem_req", 32'(dmemIf.dmem_req), 32'(e.req));
                checkOutput("mem_stall", 32'(memStall), 32'(e.stall));
                if (e.req) begin
                    checkOutput("dmem_we", 32'(dmemIf.dmem_we), 32'(e.we));
                    checkOutput("dmem_be", 32'(dmemIf.dmem_be), 32'(e.be));
                    checkOutput("dmem_addr", dmemIf.dmem_addr, e.addr);
                    checkOutput("dmem_wdata", dmemIf.dmem_wdata, e.wdata);
                end
                checkOutput("mem_wb_regwrite", 32'(wbRegwrite), 32'(e.wb.regwrite));
                checkOutput("mem_wb_result_src", 32'(wbResultSrc), 32'(e.wb.src));
                checkOutput("mem_wb_alu_result", wbAluResult, e.wb.alu);
                checkOutput("mem_wb_read_data", wbReadData, e.wb.rdata);
                checkOutput("mem_wb_pc_plus_4", wbPcPlus4, e.wb.pc);
                checkOutput("mem_wb_rd", 32'(wbRd), 32'(e.wb.rd));
                checkOutput("misalign_fault", 32'(misalignFault), 32'(e.wb.fault));
                checkOutput("bus_error", 32'(busError), 32'(e.wb.berr));
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence with hand-computed spot checks.
    initial begin
        nop = mkOp(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        pendingWb = '0;
        reset = 1'b1;
        driveOp(mkOp(1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 32'h44, 5'd7));
        dmemIf.dmem_ready = 1'b1;
        dmemIf.dmem_rdata = 32'h11111111;
        #12;
        checkOutput("reset dmem_req", 32'(dmemIf.dmem_req), 32'h0);
        checkOutput("reset mem_stall", 32'(memStall), 32'h0);
        checkOutput("reset mem_wb_regwrite", 32'(wbRegwrite), 32'h0);
        checkOutput("reset mem_wb_alu_result", wbAluResult, 32'h0);
        checkOutput("reset misalign_fault", 32'(misalignFault), 32'h0);
        checkOutput("reset bus_error", 32'(busError), 32'h0);
        @(posedge clk);
        #1;
        driveOp(nop);
        dmemIf.dmem_ready = 1'b0;
        reset = 1'b0;

        // ALU op passes straight through
        applyStimulus(mkOp(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h10, 5'd5), 0, 32'h0);
        #2 checkOutput("alu no dmem_req", 32'(dmemIf.dmem_req), 32'h0);
        idleCycles(1);
        @(negedge clk); #1;
        checkOutput("alu mem_wb_regwrite", 32'(wbRegwrite), 32'h1);
        checkOutput("alu mem_wb_rd", 32'(wbRd), 32'd5);
        checkOutput("alu mem_wb_alu_result", wbAluResult, 32'h1234);

        // sb zero-wait to the top byte lane
        stallCount = 0;
        applyStimulus(mkOp(1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h14, 5'd0), 0, 32'h0);
        #2;
        checkOutput("sb be", 32'(dmemIf.dmem_be), 32'h8);
        checkOutput("sb wdata", dmemIf.dmem_wdata, 32'hABABABAB);
        checkOutput("sb addr", dmemIf.dmem_addr, 32'h100);
        idleCycles(1);
        checkOutput("sb stall cycles", 32'(stallCount), 32'd0);

        // lb with three wait-states
        stallCount = 0;
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b000, 32'h102, 32'h0, 32'h18, 5'd9), 3, 32'h00800000);
        idleCycles(1);
        @(negedge clk); #1;
        checkOutput("lb read_data", wbReadData, 32'hFFFFFF80);
        checkOutput("lb stall cycles", 32'(stallCount), 32'd3);

        // lbu, same word
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b100, 32'h102, 32'h0, 32'h1C, 5'd10), 3, 32'h00800000);
        idleCycles(1);
        @(negedge clk); #1;
        checkOutput("lbu read_data", wbReadData, 32'h00000080);

        // misaligned lw
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 32'h20, 5'd11), 0, 32'h0);
        #2 checkOutput("lw misaligned dmem_req", 32'(dmemIf.dmem_req), 32'h0);
        idleCycles(1);
        @(negedge clk); #1;
        checkOutput("lw misaligned fault", 32'(misalignFault), 32'h1);
        checkOutput("lw misaligned regwrite", 32'(wbRegwrite), 32'h0);
        idleCycles(1);
        @(negedge clk); #1;
        checkOutput("misalign pulse width", 32'(misalignFault), 32'h0);

        // assorted sizes, lanes and illegal encodings
        applyStimulus(mkOp(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h24, 5'd0), 1, 32'h0);
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b001, 32'h102, 32'h0, 32'h28, 5'd12), 0, 32'h80010000);
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b101, 32'h100, 32'h0, 32'h2C, 5'd13), 2, 32'h1234F00D);
        applyStimulus(mkOp(1'b0, 2'b00, 1'b1, 3'b010, 32'h104, 32'hCAFEBABE, 32'h30, 5'd0), 2, 32'h0);
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b010, 32'h108, 32'h0, 32'h34, 5'd14), 0, 32'hCAFEF00D);
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b000, 32'h101, 32'h0, 32'h38, 5'd15), 1, 32'h00007F00);
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b011, 32'h100, 32'h0, 32'h3C, 5'd16), 0, 32'h0);
        applyStimulus(mkOp(1'b0, 2'b00, 1'b1, 3'b100, 32'h100, 32'h55, 32'h40, 5'd0), 0, 32'h0);
        applyStimulus(mkOp(1'b1, 2'b10, 1'b0, 3'b000, 32'h777, 32'h0, 32'h48, 5'd1), 0, 32'h0);

        // timeout with ready held low
        stallCount = 0;
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h50, 5'd17), 100, 32'h0);
        idleCycles(1);
        @(negedge clk); #1;
        checkOutput("timeout bus_error", 32'(busError), 32'h1);
        checkOutput("timeout mem_stall", 32'(memStall), 32'h0);
        checkOutput("timeout stall cycles", 32'(stallCount), 32'd4);
        idleCycles(1);

        // reset in the middle of a WAIT
        @(posedge clk); #1;
        driveOp(mkOp(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 32'h60, 5'd18));
        dmemIf.dmem_ready = 1'b0;
        @(posedge clk); #2;
        checkOutput("pre-reset dmem_req", 32'(dmemIf.dmem_req), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("mid-reset dmem_req", 32'(dmemIf.dmem_req), 32'h0);
        checkOutput("mid-reset mem_stall", 32'(memStall), 32'h0);
        checkOutput("mid-reset wb", {wbRegwrite, wbResultSrc, wbRd, wbAluResult[23:0]}, 32'h0);
        checkOutput("mid-reset wb data", wbReadData | wbPcPlus4 | wbAluResult, 32'h0);
        @(posedge clk); #1;
        driveOp(nop);
        reset = 1'b0;
        pendingWb = '0;
        applyStimulus(mkOp(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 32'h64, 5'd19), 1, 32'hDEADBEEF);
        idleCycles(1);
        @(negedge clk); #1;
        checkOutput("post-reset lw read_data", wbReadData, 32'hDEADBEEF);
        checkOutput("post-reset lw regwrite", 32'(wbRegwrite), 32'h1);
        idleCycles(2);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
